// File: rtl/response_capture.sv
// response_capture
//   Watches a DUT output bus and records every value change, together with a
//   cycle timestamp, into a small show-ahead FIFO drained via valid/ready.
//
//   Ports
//     clk, rst      : single clock, synchronous active-high reset
//     en            : capture enable; timestamp and change history hold when low
//     y_in          : observed bus
//     out_valid     : FIFO head entry available
//     out_ready     : consumer accepts head entry
//     out_data      : captured value at FIFO head (zero while empty)
//     out_ts        : timestamp of FIFO head entry (zero while empty)
//     count         : FIFO occupancy, 0..DEPTH
//     overflow      : sticky, set when a change was dropped on a full FIFO
//     change_cnt    : saturating count of all detected changes
module response_capture #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TS_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DATA_W-1:0]       y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [TS_W-1:0]         out_ts,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [15:0]             change_cnt
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [TS_W-1:0]   ts_mem_q   [DEPTH];

   logic [TS_W-1:0]   ts_q,      ts_d;
   logic [DATA_W-1:0] prev_q;
   logic              first_q;
   logic [AW-1:0]     wr_q,      wr_d;
   logic [AW-1:0]     rd_q,      rd_d;
   logic [AW:0]       cnt_q,     cnt_d;
   logic              ovf_q;
   logic [15:0]       chg_cnt_q, chg_cnt_d;

   logic full, pop, chg, push;

   always_comb begin
      full = (cnt_q == FULL_CNT);
      pop  = (cnt_q != '0) && out_ready;
      chg  = en && (first_q || (y_in != prev_q));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = chg && (!full || pop);

      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
         cnt_d = cnt_q - 1'b1;
      end

      wr_d      = push ? wr_q + 1'b1 : wr_q;
      rd_d      = pop  ? rd_q + 1'b1 : rd_q;
      ts_d      = en   ? ts_q + 1'b1 : ts_q;
      chg_cnt_d = (chg && (chg_cnt_q != '1)) ? chg_cnt_q + 1'b1 : chg_cnt_q;
   end

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_q] <= y_in;
         ts_mem_q[wr_q]   <= ts_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q      <= '0;
         prev_q    <= '0;
         first_q   <= 1'b1;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         chg_cnt_q <= '0;
      end else begin
         ts_q      <= ts_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         chg_cnt_q <= chg_cnt_d;
         if (en) begin
            prev_q  <= y_in;
            first_q <= 1'b0;
         end
         if (chg && !push) begin
            ovf_q <= 1'b1;
         end
      end
   end

   always_comb begin
      out_valid  = (cnt_q != '0);
      // Head is forced to zero while empty so reset leaves clean outputs.
      out_data   = out_valid ? data_mem_q[rd_q] : '0;
      out_ts     = out_valid ? ts_mem_q[rd_q]   : '0;
      count      = cnt_q;
      overflow   = ovf_q;
      change_cnt = chg_cnt_q;
   end

endmodule

// File: doc/response_capture.md
Name: response_capture

Overview:
- Observes a DUT's 32-bit output bus, detects value changes, and stores each change with a cycle timestamp in a small FIFO.
- A downstream consumer drains the FIFO through a valid/ready handshake.
- Acts as the receiving end of stimulus sequences applied to test designs. It produces a compact change trace for comparison against expected or golden traces.
- Sits next to the DUT, on the DUT's output side.

Parameters:
- DATA_W, 32, width of observed bus and captured data
- DEPTH, 8, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture enable; when low, nothing is captured and the timestamp holds
- y_in  input  DATA_W  observed DUT output bus
- out_valid  output  1  FIFO head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  DATA_W  captured value at FIFO head
- out_ts  output  TS_W  timestamp of FIFO head entry
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: at least one change was dropped
- change_cnt  output  16  total detected changes, saturating

Behaviour:
- Reset (rst=1 at a clock edge) clears all state:
  - out_valid=0, out_data=0, out_ts=0, count=0, overflow=0, change_cnt=0
  - timestamp=0, prev=0, first flag set, read/write pointers=0
- Reset mid-operation discards all FIFO contents and clears all state, regardless of en or out_ready.
- Timestamp ts:
  - increments by 1 on every clock edge where en=1
  - wraps from 2^TS_W-1 to 0
  - holds while en=0
- Change detect: `chg = en && (first || y_in != prev)`.
  - When en=1: prev <= y_in and first <= 0.
  - When en=0: prev and first hold.
  - The first enabled cycle after reset always produces an entry, carrying the initial value.
- Captured entry: {y_in, ts}, where ts is the value before the increment. The first entry after reset therefore has ts=0.
- Push: push = chg && (!full || pop).
  - If chg && full && !pop: entry is dropped and overflow <= 1.
  - overflow stays set until reset.
- Pop: pop = out_valid && out_ready.
- FIFO is show-ahead:
  - out_valid = (count != 0)
  - out_data/out_ts driven from the head entry, stable while out_valid=1 and out_ready=0
  - when count=0, out_data/out_ts are don't-care
- Latency: a change sampled at edge N appears at the outputs with out_valid=1 after edge N (one cycle).
- Push and pop in the same cycle:
  - count is unchanged
  - allowed when full (entry accepted) and when count=1 (the new entry becomes head after the edge)
  - no push on empty FIFO bypasses the register stage; minimum latency is always 1
- count:
  - +1 on push-only, -1 on pop-only, unchanged otherwise
  - never exceeds DEPTH, never underflows
- Pointers wrap modulo DEPTH; full = (count == DEPTH).
- change_cnt increments on every chg, including dropped entries, and saturates at 16'hFFFF.
- out_ready while out_valid=0 has no effect.

Test Plan:
1. Reset, then en=1, y_in=0 held 4 cycles, out_ready=1 -> exactly one entry {0, ts=0}; change_cnt=1; count returns to 0.
2. en=1, out_ready=0; y_in sequence 0, 1, 1, 0x1000, 0x10000000 on consecutive cycles -> 4 entries: (0,0), (1,1), (0x1000,3), (0x10000000,4); count=4; change_cnt=4.
3. DEPTH=8, out_ready=0; y_in changes on 10 consecutive cycles -> count=8; overflow=1 from the 9th change; change_cnt=10; drained data are the first 8 values in order.
4. FIFO full, change with out_ready=1 in the same cycle -> head popped, new entry accepted, count stays 8, overflow stays 0.
5. Toggle en: en=0 for 3 cycles while y_in changes, then en=1 -> no entries during en=0; ts frozen; first entry after re-enable shows the new value with the held ts.
6. Drive 5 entries, assert rst for 1 cycle with out_ready=1 -> next cycle out_valid=0, count=0, overflow=0, change_cnt=0; first enabled cycle captures with ts=0.
